// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for a single-port data memory. The grant is combinational (0 cycles) and read data returns 1 cycle after the grant.
// The core has fixed priority. A denied request stalls and must be held; a saturating wait counter bounds how long debug can stall.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                starved
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             at_limit;
  logic             d_win;

  assign at_limit = (wait_cnt_q == LIMIT);

  always_comb begin
    d_win   = d_req & (~c_req | at_limit);
    c_gnt   = c_req & ~d_win;
    d_gnt   = d_win;
    starved = d_req & c_req & at_limit;
    m_en    = c_gnt | d_gnt;
    // Idle cycles leave the mux on the core side; only m_en matters then.
    m_we    = d_win ? d_we    : c_we;
    m_addr  = d_win ? d_addr  : c_addr;
    m_wdata = d_win ? d_wdata : c_wdata;
    m_be    = d_win ? d_be    : c_be;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!d_req || d_gnt) begin
      wait_cnt_d = '0;
    end else if (!at_limit) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    rd_pend_d  = m_en & ~m_we;
    rd_owner_d = d_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign c_rvalid = rd_pend_q & ~rd_owner_q;
  assign d_rvalid = rd_pend_q &  rd_owner_q;
  assign c_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port synchronous data memory behind the RISC-V data path. It shares the memory between the core load/store stage (port `c_`) and a debug/loader master (port `d_`), which preloads or inspects data memory while the core runs. The core has fixed priority. A wait counter guarantees the debug master a grant after a bounded stall. Read data returns one cycle after grant, tagged per requester.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; must be a multiple of 8
- `STARVE_LIMIT`, 4, number of consecutive denied debug cycles before debug wins a conflict; 0 means debug always wins

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `c_req`  in  1  core request valid
- `c_we`  in  1  core write enable (0 = read)
- `c_addr`  in  ADDR_W  core address
- `c_wdata`  in  DATA_W  core write data
- `c_be`  in  DATA_W/8  core byte enables
- `c_gnt`  out  1  core request accepted this cycle
- `c_rvalid`  out  1  core read data valid
- `c_rdata`  out  DATA_W  core read data
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_be`, `d_gnt`, `d_rvalid`, `d_rdata`: same as the `c_` ports, for the debug master
- `m_en`  out  1  memory access strobe
- `m_we`  out  1  memory write enable
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_be`  out  DATA_W/8  memory byte enables
- `m_rdata`  in  DATA_W  memory read data, valid the cycle after `m_en` with `m_we`=0
- `starved`  out  1  debug-priority override active this cycle

## Operation
- Winner selection is combinational from requests and registered state:
  - only `c_req`: core wins
  - only `d_req`: debug wins
  - both: debug wins if `wait_cnt == STARVE_LIMIT`, otherwise core wins
- `c_gnt`/`d_gnt` are asserted for the winner only. They are mutually exclusive and never asserted without the matching request.
- `m_en` = `c_gnt | d_gnt`. `m_we`/`m_addr`/`m_wdata`/`m_be` mux from the winner.
  - When idle, the muxes select core inputs; only `m_en` = 0 matters.
- A request that is not granted must be held, with stable attributes, until granted. The arbiter does not queue requests.
- `wait_cnt` has width clog2(STARVE_LIMIT+1), minimum 1:
  - clears on `d_gnt` or when `d_req` = 0
  - increments when `d_req & ~d_gnt`
  - saturates at `STARVE_LIMIT`
- `starved` = `d_req & c_req & (wait_cnt == STARVE_LIMIT)`.
- Return path:
  - register `rd_owner` (0 = core, 1 = debug) and `rd_pend`; both load each cycle with the winner and `m_en & ~m_we`
  - `c_rvalid` = `rd_pend & ~rd_owner`; `d_rvalid` = `rd_pend & rd_owner`
  - `c_rdata` = `d_rdata` = `m_rdata` (unqualified; consumers qualify with rvalid)
- Writes complete on the grant cycle and produce no rvalid.
- Back-to-back grants are allowed every cycle, including alternating owners. Each return is tagged by the registered owner.

## Timing
- Reset values: `wait_cnt` = 0, `rd_pend` = 0, `rd_owner` = 0. Hence `c_rvalid` = `d_rvalid` = 0.
- Combinational outputs follow their inputs during reset:
  - requesters must hold `req` low during reset
  - with `req` low, `c_gnt` = `d_gnt` = `m_en` = `starved` = 0
- Grant latency: 0 cycles; same cycle as the request when uncontested.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Worst-case debug wait under continuous core traffic: `STARVE_LIMIT` denied cycles, granted on cycle `STARVE_LIMIT`+1.
- After a debug grant, `wait_cnt` = 0, so the core wins the next conflict (unless `STARVE_LIMIT` = 0).
- Reset asserted mid-read, i.e. between grant and return: the pending rvalid is dropped, and no rvalid is asserted after reset release.
- No combinational path from `m_rdata` to any grant or `m_*` output.

## Test plan
- Reset, then a core-only read of addr 0x0 with memory word 0x11223344: `c_gnt` = 1 in cycle N; `c_rvalid` = 1 with `c_rdata` = 0x11223344 in N+1; `d_rvalid` stays 0.
- Debug-only writes: 0xDEADBEEF to 0x10 with `be` = 4'hF, then a read of 0x10. `d_gnt` each cycle, and `d_rdata` = 0xDEADBEEF the cycle after the read grant.
- Continuous `c_req` plus held `d_req`, `STARVE_LIMIT` = 4:
  - `d_gnt` low for 4 cycles, then high in cycle 5 with `starved` = 1 and `c_gnt` = 0
  - core wins cycle 6
  - repeats with a period of 5
- `STARVE_LIMIT` = 0, both requesting every cycle: `d_gnt` = 1 every cycle, `c_gnt` = 0.
- Alternating reads (core 0x4, debug 0x8, core 0xC) in consecutive cycles: rvalids alternate c/d/c, each carrying the correct word for its own address.
- Core read granted, then `rst` pulsed before the next edge: `c_rvalid` = 0 after reset release, and `wait_cnt` returns to 0 (a subsequent conflict grants the core).
